// File: rtl/link_fault_sm.sv
// XGMII receive link-fault monitor: decodes LF/RF ordered sets per column,
// qualifies faults and drives fault status, RS tx mode and event counters.
module link_fault_sm #(
  parameter int DATA_W     = 64,
  parameter int SEQ_THRESH = 4,
  parameter int COL_THRESH = 128,
  parameter int CNT_W      = 16
) (
  input  logic                  rx_clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     rx_d,
  input  logic [DATA_W/8-1:0]   rx_c,
  input  logic                  clear_cnt,
  output logic [1:0]            link_fault,
  output logic [1:0]            tx_mode,
  output logic                  fault_change,
  output logic [CNT_W-1:0]      lf_cnt,
  output logic [CNT_W-1:0]      rf_cnt
);

  localparam int NCOL = DATA_W / 32;
  localparam logic [7:0]  SEQ_MAX = 8'(SEQ_THRESH);
  localparam logic [15:0] COL_MAX = 16'(COL_THRESH);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_COUNT = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  // Type codes match the link_fault encoding so a type can be copied directly.
  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_LF   = 2'b01;
  localparam logic [1:0] T_RF   = 2'b10;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       seq_q, seq_d;
  logic [15:0]      col_q, col_d;
  logic [1:0]       lf_q, lf_d;
  logic             fc_q;
  logic [CNT_W-1:0] lf_cnt_q, rf_cnt_q;
  logic [1:0]       ty;

  function automatic logic [1:0] col_type(
    input logic [31:0] d,
    input logic [3:0]  c
  );
    logic [1:0] t;
    t = T_NONE;
    if (c == 4'b0001 && d[7:0] == 8'h9C && d[23:8] == 16'h0000) begin
      if (d[31:24] == 8'h01) t = T_LF;
      else if (d[31:24] == 8'h02) t = T_RF;
    end
    return t;
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    seq_d   = seq_q;
    col_d   = col_q;
    lf_d    = lf_q;
    ty      = T_NONE;
    for (int k = 0; k < NCOL; k++) begin
      ty = col_type(rx_d[32*k +: 32], rx_c[4*k +: 4]);
      unique case (state_d)
        S_INIT: begin
          if (ty != T_NONE) begin
            last_d  = ty;
            seq_d   = 8'd1;
            col_d   = '0;
            state_d = S_COUNT;
          end
        end
        S_COUNT, S_FAULT: begin
          if (ty != T_NONE && ty == last_d) begin
            col_d = '0;
            if (state_d == S_COUNT) begin
              seq_d = seq_d + 8'd1;
              if (seq_d == SEQ_MAX) begin
                state_d = S_FAULT;
                lf_d    = last_d;
              end
            end
          end else if (ty != T_NONE) begin
            last_d  = ty;
            seq_d   = 8'd1;
            col_d   = '0;
            state_d = S_COUNT;
          end else begin
            if (col_d != COL_MAX) col_d = col_d + 16'd1;
            if (col_d == COL_MAX) begin
              state_d = S_INIT;
              lf_d    = 2'b00;
              seq_d   = '0;
              col_d   = '0;
            end
          end
        end
        default: begin
          state_d = S_INIT;
          lf_d    = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q  <= S_INIT;
      last_q   <= T_NONE;
      seq_q    <= '0;
      col_q    <= '0;
      lf_q     <= 2'b00;
      fc_q     <= 1'b0;
      lf_cnt_q <= '0;
      rf_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      seq_q   <= seq_d;
      col_q   <= col_d;
      lf_q    <= lf_d;
      fc_q    <= (lf_d != lf_q);
      if (clear_cnt) begin
        lf_cnt_q <= '0;
        rf_cnt_q <= '0;
      end else begin
        if (lf_d == T_LF && lf_q != T_LF && lf_cnt_q != '1)
          lf_cnt_q <= lf_cnt_q + 1'b1;
        if (lf_d == T_RF && lf_q != T_RF && rf_cnt_q != '1)
          rf_cnt_q <= rf_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    tx_mode = 2'b00;
    unique case (lf_q)
      2'b01:   tx_mode = 2'b10;
      2'b10:   tx_mode = 2'b01;
      default: tx_mode = 2'b00;
    endcase
  end

  assign link_fault   = lf_q;
  assign fault_change = fc_q;
  assign lf_cnt       = lf_cnt_q;
  assign rf_cnt       = rf_cnt_q;

endmodule
